// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions used by the fetch stage and the decode stage:
//   XLEN / ILEN        - datapath and instruction widths (32)
//   NOP_INSTR          - canonical NOP (addi x0, x0, 0)
//   if_state_e         - fetch-stage control states (BOOT, FETCH, DRAIN)
//   imm_src_e          - immediate format selector used by the decoder
//   fetch_entry_t      - one buffered fetch result {pc, instr}
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } if_state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Registered (non fall-through) synchronous FIFO of {pc, instr} pairs that
// buffers fetched instructions in front of decode. A push lands in the
// storage at the clock edge, so data is visible on the head one cycle later.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clr             - synchronous flush (empties the FIFO, wins over push/pop)
//   push            - write {push_pc, push_instr}
//   pop             - remove head entry (ignored while empty)
//   count           - number of valid entries
//   head_pc         - PC of the oldest entry
//   head_instr      - instruction word of the oldest entry
// -----------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [XLEN-1:0]              push_pc,
  input  logic [ILEN-1:0]              push_instr,
  input  logic                         pop,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic [XLEN-1:0]              head_pc,
  output logic [ILEN-1:0]              head_instr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
  logic [ILEN-1:0]  instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_push;
  logic do_pop;

  // Popping an empty FIFO is harmless; a push into a full FIFO is only legal
  // together with a pop, which the issue throttle upstream guarantees.
  assign do_push = push & ~clr;
  assign do_pop  = pop & ~clr & (count_reg != '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is reset so the head reads back as zero straight out of reset.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        pc_mem[gi]    <= '0;
        instr_mem[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        pc_mem[gi]    <= push_pc;
        instr_mem[gi] <= push_instr;
      end
    end
  end

  assign count      = count_reg;
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// RV32 instruction fetch stage. Owns the PC, issues word requests on a
// req/gnt/rvalid instruction-memory interface, buffers returned words with
// their PCs in fetch_fifo and presents them to decode on a valid/ready
// handshake. A redirect flushes everything in flight; responses to requests
// granted before the redirect are counted and discarded in DRAIN.
//
// Parameters:
//   RESET_PC     - first fetch address after reset
//   FIFO_DEPTH   - output buffer entries and max outstanding requests (2^n, >=2)
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   imem_req / imem_addr          - fetch request and word address
//   imem_gnt                      - request accepted this cycle
//   imem_rvalid / imem_rdata      - in-order response
//   redirect / redirect_pc        - flush and restart at redirect_pc
//   id_valid / id_ready           - handshake to decode
//   id_instr / id_pc              - instruction word and its PC
//   fetch_misalign                - one-cycle pulse: redirect_pc[1:0] != 0
//   perf_fetch_cnt (optional)     - wrapping count of decode handshakes
//   perf_stall_cnt (optional)     - wrapping count of id_ready & !id_valid
//
// Optional feature macro: IF_PERF_CNT_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
`endif
  output logic            fetch_misalign
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if_state_e        state_reg, state_next;
  logic [XLEN-1:0]  pc_reg;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic             misalign_reg;

  // In-flight PC queue: PCs of granted requests awaiting their response.
  logic [XLEN-1:0]  ifq_pc_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] ifq_wr_ptr_reg;
  logic [PTR_W-1:0] ifq_rd_ptr_reg;
  logic [CNT_W-1:0] ifq_cnt_reg;

  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   busy;
  logic [CNT_W-1:0] stale_total;
  logic             grant;
  logic             resp_accept;
  logic             id_fire;

  // ---------------------------------------------------------------------------
  // Issue / accept
  // ---------------------------------------------------------------------------
  // Outstanding requests plus buffered words may never exceed the buffer, so
  // every response is guaranteed a FIFO slot when it arrives.
  assign busy        = {1'b0, ifq_cnt_reg} + {1'b0, fifo_cnt};
  assign imem_req    = (state_reg == FETCH) & ~redirect & (busy < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr   = pc_reg;
  assign grant       = imem_req & imem_gnt;
  assign resp_accept = imem_rvalid & (state_reg == FETCH) & ~redirect;

  assign id_valid    = (fifo_cnt != '0) & ~redirect;
  assign id_fire     = id_valid & id_ready;

  // Responses still owed after a redirect: everything granted and not yet
  // returned (in-flight queue in FETCH, drop counter in DRAIN), plus a grant
  // this cycle, minus a response this cycle.
  assign stale_total = ifq_cnt_reg + drop_reg + CNT_W'(grant) - CNT_W'(imem_rvalid);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
      drop_reg  <= '0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    case (state_reg)
      BOOT:  state_next = FETCH;
      FETCH: state_next = FETCH;
      DRAIN: begin
        if (imem_rvalid && (drop_reg != '0)) drop_next = drop_reg - CNT_W'(1);
        if (drop_next == '0) state_next = FETCH;
      end
      default: state_next = BOOT;
    endcase
    // Redirect overrides any other transition, including one from DRAIN.
    if (redirect) begin
      drop_next  = stale_total;
      state_next = (stale_total != '0) ? DRAIN : FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter and misalign flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= {RESET_PC[31:2], 2'b00};
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= redirect & (|redirect_pc[1:0]);
      if (redirect)   pc_reg <= {redirect_pc[31:2], 2'b00};
      else if (grant) pc_reg <= pc_reg + 32'd4;
    end
  end

  assign fetch_misalign = misalign_reg;

  // ---------------------------------------------------------------------------
  // In-flight PC queue (grant pushes, accepted response pops, redirect clears)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      ifq_wr_ptr_reg <= '0;
      ifq_rd_ptr_reg <= '0;
      ifq_cnt_reg    <= '0;
    end else begin
      if (grant)       ifq_wr_ptr_reg <= ifq_wr_ptr_reg + PTR_W'(1);
      if (resp_accept) ifq_rd_ptr_reg <= ifq_rd_ptr_reg + PTR_W'(1);
      case ({grant, resp_accept})
        2'b10:   ifq_cnt_reg <= ifq_cnt_reg + CNT_W'(1);
        2'b01:   ifq_cnt_reg <= ifq_cnt_reg - CNT_W'(1);
        default: ifq_cnt_reg <= ifq_cnt_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ifq
    always_ff @(posedge clk) begin
      if (rst) begin
        ifq_pc_mem[gi] <= '0;
      end else if (grant && (ifq_wr_ptr_reg == PTR_W'(gi))) begin
        ifq_pc_mem[gi] <= pc_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (redirect),
    .push       (resp_accept),
    .push_pc    (ifq_pc_mem[ifq_rd_ptr_reg]),
    .push_instr (imem_rdata),
    .pop        (id_fire),
    .count      (fifo_cnt),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

`ifdef IF_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] perf_fetch_cnt_reg;
  logic [31:0] perf_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_reg <= '0;
      perf_stall_cnt_reg <= '0;
    end else begin
      if (id_fire)               perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
      if (id_ready && !id_valid) perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A memory model answers granted requests
// in order after a programmable latency with mem[a] = a ^ 32'h1357_0013.
// A reference model tracks, at the level of the fetch contract, which PC
// decode must see next, how many responses are owed/stale and how many words
// are buffered, and checks the DUT every cycle. A second instance with
// RESET_PC = 0xFFFF_FFFC checks address wrap-around from reset.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        fetch_misalign;

  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc;
  logic        w_gnt, w_rvalid, w_redirect, w_ready;
  logic [31:0] w_rdata, w_redirect_pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [31:0] w_pf, w_ps;
`endif

  if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .fetch_misalign(fetch_misalign)
  );

  if_stage #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .id_valid(w_valid), .id_ready(w_ready), .id_instr(w_instr), .id_pc(w_pc),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(w_pf), .perf_stall_cnt(w_ps),
`endif
    .fetch_misalign(w_mis)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_0013;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory model + reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  int          since, stale, buffered, hs_cnt, stall_cnt, outst;
  logic [31:0] exp_pc, exp_gaddr;
  logic        exp_mis, exp_req, exp_val;
  int          first_gnt_cyc = -1;
  int          first_val_cyc = -1;
  logic [31:0] first_hs_pc, first_hs_instr;
  logic [31:0] gaddr_log [3];
  int          gnt_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (rst) begin
        since = 0; stale = 0; buffered = 0; hs_cnt = 0; stall_cnt = 0;
        mq.delete();
        exp_pc = RST_PC; exp_gaddr = RST_PC; exp_mis = 1'b0;
      end else begin
        since++;
        outst   = mq.size() + (imem_rvalid ? 1 : 0);
        exp_req = (since >= 2) && (stale == 0) && !redirect && (outst + buffered < DEPTH);
        exp_val = (buffered > 0) && !redirect;
        check1("imem_req", imem_req, exp_req);
        check1("id_valid", id_valid, exp_val);
        check1("fetch_misalign", fetch_misalign, exp_mis);
`ifdef IF_PERF_CNT_EN
        check32("perf_fetch_cnt", perf_fetch_cnt, hs_cnt);
        check32("perf_stall_cnt", perf_stall_cnt, stall_cnt);
`endif
        if (id_valid && first_val_cyc < 0) first_val_cyc = cyc;
        // Response this cycle: stale ones are discarded, fresh ones buffered.
        if (imem_rvalid) begin
          if (stale > 0) stale--;
          else buffered++;
        end
        if (imem_req && imem_gnt) begin
          check32("imem_addr", imem_addr, exp_gaddr);
          mq.push_back('{addr: imem_addr, due: cyc + lat});
          if (gnt_seen < 3) gaddr_log[gnt_seen] = imem_addr;
          gnt_seen++;
          if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
          exp_gaddr = exp_gaddr + 32'd4;
        end
        if (exp_val && id_ready) begin
          check32("id_pc", id_pc, exp_pc);
          check32("id_instr", id_instr, mem_word(exp_pc));
          if (hs_cnt == 0) begin
            first_hs_pc    = id_pc;
            first_hs_instr = id_instr;
          end
          exp_pc = exp_pc + 32'd4;
          buffered--;
          hs_cnt++;
        end
        if (id_ready && !exp_val) stall_cnt++;
        exp_mis = 1'b0;
        if (redirect) begin
          stale     = mq.size();
          buffered  = 0;
          exp_pc    = {redirect_pc[31:2], 2'b00};
          exp_gaddr = {redirect_pc[31:2], 2'b00};
          exp_mis   = |redirect_pc[1:0];
        end
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = pc;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic wait_hs(input string name, input logic [31:0] pc);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (id_valid && id_ready) begin
        got = 1;
        check32(name, id_pc, pc);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for handshake, expected pc=%h", name, pc);
    end
  endtask

  logic [31:0] gnt_pat, rdy_pat;

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0; w_redirect = 1'b0;
    w_redirect_pc = 32'h0; w_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst imem_req", imem_req, 1'b0);
    check32("rst imem_addr", imem_addr, 32'h0);
    check1("rst id_valid", id_valid, 1'b0);
    check32("rst id_instr", id_instr, 32'h0);
    check32("rst id_pc", id_pc, 32'h0);
    check1("rst fetch_misalign", fetch_misalign, 1'b0);
    check32("rst wrap imem_addr", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    rst = 1'b0;

    // Boot timing and wrap-around from RESET_PC = 0xFFFF_FFFC.
    @(negedge clk);
    check1("boot cycle1 imem_req", w_req, 1'b0);
    @(negedge clk);
    check1("wrap req0", w_req, 1'b1);
    check32("wrap addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check1("wrap req1", w_req, 1'b1);
    check32("wrap addr1", w_addr, 32'h0000_0000);
    @(negedge clk);
    check1("wrap req throttled", w_req, 1'b0);
    check32("wrap addr2", w_addr, 32'h0000_0004);

    // Reset boot with 1-cycle memory.
    step(12);
    check32("boot grant addr0", gaddr_log[0], 32'h0);
    check32("boot grant addr1", gaddr_log[1], 32'h4);
    check32("boot grant addr2", gaddr_log[2], 32'h8);
    check32("boot first id_pc", first_hs_pc, 32'h0);
    check32("boot first id_instr", first_hs_instr, 32'h1357_0013);
    check32("boot grant->valid latency", first_val_cyc - first_gnt_cyc, 32'd2);

    // Backpressure: requests stop once buffer + outstanding fills.
    id_ready = 1'b0;
    step(8);
    @(negedge clk);
    check1("backpressure imem_req", imem_req, 1'b0);
    check1("backpressure id_valid", id_valid, 1'b1);
    @(posedge clk); #1;
    id_ready = 1'b1;
    step(10);

    // Redirect with outstanding requests (slow memory).
    lat = 3;
    step(8);
    do_redirect(32'h0000_0100);
    wait_hs("redirect first id_pc", 32'h0000_0100);
    step(4);

    // Redirect coinciding with a response (streaming memory).
    lat = 1;
    step(8);
    do_redirect(32'h0000_0200);
    wait_hs("redirect+resp first id_pc", 32'h0000_0200);
    step(4);

    // Misaligned redirect.
    do_redirect(32'h0000_0102);
    @(negedge clk);
    check1("misalign pulse", fetch_misalign, 1'b1);
    @(negedge clk);
    check1("misalign cleared", fetch_misalign, 1'b0);
    wait_hs("misalign resume id_pc", 32'h0000_0100);
    step(4);

    // Back-to-back redirects, the second one landing in DRAIN.
    lat = 4;
    step(8);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    @(posedge clk); #1;
    redirect_pc = 32'h0000_0400;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_hs("drain redirect id_pc", 32'h0000_0400);
    step(4);

    // PC wrap through a redirect.
    lat = 1;
    do_redirect(32'hFFFF_FFF8);
    wait_hs("wrap hs0", 32'hFFFF_FFF8);
    wait_hs("wrap hs1", 32'hFFFF_FFFC);
    wait_hs("wrap hs2", 32'h0000_0000);
    step(4);

    // Irregular grant and ready patterns.
    lat = 2;
    gnt_pat = 32'b1011_0110_1110_0101_1101_0011_0111_1001;
    rdy_pat = 32'b1110_1001_0111_1100_1011_0101_1001_1111;
    for (int i = 0; i < 64; i++) begin
      imem_gnt = gnt_pat[i % 32];
      id_ready = rdy_pat[(i * 7) % 32];
      if (i == 40) begin
        redirect = 1'b1; redirect_pc = 32'h0000_0800;
      end else begin
        redirect = 1'b0;
      end
      step(1);
    end
    imem_gnt = 1'b1; id_ready = 1'b1; redirect = 1'b0;
    step(12);

`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    check32("perf_fetch_cnt final", perf_fetch_cnt, hs_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
